// File: rtl/bsg_rr_arb_mux_one_hot_reg.sv
// Registered round-robin arbitration stage.
// Grants one of els_p requesting channels per cycle with a fair rotating
// one-hot grant, selects the winner's payload through an AND-OR mux and holds
// it in a single-entry output register drained with a valid/ready handshake.
module bsg_rr_arb_mux_one_hot_reg #(
   parameter int width_p = 9,
   parameter int els_p   = 5
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic [els_p-1:0]           v_i,
   input  logic [els_p*width_p-1:0]   data_i,
   output logic [els_p-1:0]           yumi_o,
   output logic                       v_o,
   output logic [width_p-1:0]         data_o,
   output logic [els_p-1:0]           sel_one_hot_o,
   input  logic                       ready_i
);

   localparam int ptr_w_lp = $clog2(els_p);

   logic [ptr_w_lp-1:0] last_r;
   logic [ptr_w_lp-1:0] grant_idx;
   logic [els_p-1:0]    grant;
   logic [width_p-1:0]  mux_data;
   logic                space;
   logic                any_v;

   // The register can take a new item when it is empty or draining now.
   assign space = ~v_o | ready_i;
   assign any_v = |v_i;

   // Cyclic search for the first requester after the last winner.
   // NOTE: every variable written here gets a default first, otherwise paths
   // that skip an assignment would infer a latch.
   always_comb begin : grant_search
      logic found;
      int   cand;
      grant     = '0;
      grant_idx = last_r;
      found     = 1'b0;
      cand      = 0;
      for (int i = 1; i <= els_p; i++) begin
         cand = int'(last_r) + i;
         if (cand >= els_p) cand = cand - els_p;
         if (!found && v_i[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = ptr_w_lp'(cand);
         end
      end
   end

   // AND-OR one-hot mux: only the granted channel's payload survives.
   always_comb begin
      mux_data = '0;
      for (int k = 0; k < els_p; k++) begin
         mux_data = mux_data | (data_i[k*width_p +: width_p] & {width_p{grant[k]}});
      end
   end

   // Consume the winner only when the output register can take it; this is
   // the intended combinational path from ready_i to yumi_o.
   assign yumi_o = (space & reset_n_i) ? grant : '0;

   // Output register and round-robin pointer.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_o           <= 1'b0;
         data_o        <= '0;
         sel_one_hot_o <= '0;
         last_r        <= ptr_w_lp'(els_p - 1);
      end else if (space) begin
         if (any_v) begin
            v_o           <= 1'b1;
            data_o        <= mux_data;
            sel_one_hot_o <= grant;
            last_r        <= grant_idx;
         end else begin
            v_o           <= 1'b0;
            sel_one_hot_o <= '0;
         end
      end
   end

endmodule
